// File: rtl/bridge_pkg.sv
// Shared entry-field constants and sequencer state type for the read side
// of the AHB-to-SPI bridge.
package bridge_pkg;

  localparam int RW_BIT   = 40;
  localparam int ADDR_MSB = 39;
  localparam int ADDR_LSB = 32;
  localparam int DATA_MSB = 31;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/seq_timeout_cnt.sv
// Wait-phase watchdog: counts cycles while enabled and flags the last
// permitted cycle before a missing spi_done is declared.
module seq_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= {CW{1'b0}};
    end else if (i_clear) begin
      r_count <= {CW{1'b0}};
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Read-domain command sequencer: pops one FIFO command, runs it on the SPI
// master and returns a valid/ready response, one command in flight.
module spi_cmd_sequencer
  import bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 41,
  parameter int SPI_ADDR_WIDTH = 8,
  parameter int SPI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst_n,
  input  logic                      enable,
  input  logic                      fifo_empty,
  input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
  output logic                      fifo_rd_en,
  output logic                      spi_start,
  output logic                      spi_rw,
  output logic [SPI_ADDR_WIDTH-1:0] spi_addr,
  output logic [SPI_DATA_WIDTH-1:0] spi_wdata,
  input  logic                      spi_busy,
  input  logic                      spi_done,
  input  logic [SPI_DATA_WIDTH-1:0] spi_rdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [SPI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [SPI_ADDR_WIDTH-1:0] rsp_addr,
  output logic                      rsp_err,
  output logic                      seq_busy,
  output logic [CNT_WIDTH-1:0]      txn_count
);

  seq_state_t r_state;
  seq_state_t w_next_state;

  logic w_pop;
  logic w_cnt_clear;
  logic w_cnt_en;
  logic w_expired;
  logic w_handshake;
  logic w_finish;

  logic                      r_spi_start;
  logic                      r_spi_rw;
  logic [SPI_ADDR_WIDTH-1:0] r_spi_addr;
  logic [SPI_DATA_WIDTH-1:0] r_spi_wdata;
  logic                      r_rsp_valid;
  logic [SPI_DATA_WIDTH-1:0] r_rsp_rdata;
  logic [SPI_ADDR_WIDTH-1:0] r_rsp_addr;
  logic                      r_rsp_err;
  logic                      r_seq_busy;
  logic [CNT_WIDTH-1:0]      r_txn_count;

  assign w_handshake = r_rsp_valid && rsp_ready;
  assign w_finish    = (r_state == ST_WAIT) && (spi_done || w_expired);

  seq_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (rd_clk),
    .i_rst_n   (rd_rst_n),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_en),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_cnt_clear  = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && !fifo_empty && !spi_busy) begin
          w_pop        = 1'b1;
          w_next_state = ST_POP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_POP: begin
        w_next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_cnt_clear  = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        // spi_done takes priority over an expiry in the same cycle
        if (spi_done) begin
          w_next_state = ST_RESP;
        end else if (w_expired) begin
          w_next_state = ST_RESP;
        end else begin
          w_cnt_en     = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (w_handshake) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      r_spi_start <= 1'b0;
      r_spi_rw    <= 1'b0;
      r_spi_addr  <= {SPI_ADDR_WIDTH{1'b0}};
      r_spi_wdata <= {SPI_DATA_WIDTH{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {SPI_DATA_WIDTH{1'b0}};
      r_rsp_addr  <= {SPI_ADDR_WIDTH{1'b0}};
      r_rsp_err   <= 1'b0;
      r_seq_busy  <= 1'b0;
      r_txn_count <= {CNT_WIDTH{1'b0}};
    end else begin
      r_spi_start <= (r_state == ST_POP);
      r_seq_busy  <= (w_next_state != ST_IDLE);
      if (r_state == ST_POP) begin
        r_spi_rw    <= fifo_rd_data[RW_BIT];
        r_spi_addr  <= fifo_rd_data[ADDR_MSB:ADDR_LSB];
        r_spi_wdata <= fifo_rd_data[DATA_MSB:0];
      end
      if (w_finish) begin
        r_rsp_valid <= 1'b1;
        r_rsp_addr  <= r_spi_addr;
        if (spi_done) begin
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= (r_spi_rw == RW_READ) ? spi_rdata : {SPI_DATA_WIDTH{1'b0}};
        end else begin
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= {SPI_DATA_WIDTH{1'b0}};
        end
      end else if (w_handshake) begin
        r_rsp_valid <= 1'b0;
        r_txn_count <= r_txn_count + CNT_WIDTH'(1);
      end
    end
  end

  // The pop strobe must lead the data by one cycle, so it is decoded from
  // state; holding reset keeps it quiet so no entry is drained during reset.
  assign fifo_rd_en = w_pop && rd_rst_n;

  assign spi_start = r_spi_start;
  assign spi_rw    = r_spi_rw;
  assign spi_addr  = r_spi_addr;
  assign spi_wdata = r_spi_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_err   = r_rsp_err;
  assign seq_busy  = r_seq_busy;
  assign txn_count = r_txn_count;

endmodule
